led_pattern_gen: RTL and testbench

Multi-channel successor to the single-LED heartbeat blinker. Drives `NUM_LEDS` outputs, each independently set to OFF, ON, BLINK or BREATHE with programmable period and PWM brightness. All timing derives from one shared millisecond tick prescaler. Sits at board top level between the clock/reset tree and the user LEDs, configured by a simple single-cycle write port from a control block or hard-tied strobes.

---
 rtl/led_pattern_pkg.sv | 18 +
 rtl/led_channel.sv | 91 +++++++++
 rtl/led_pattern_gen.sv | 84 ++++++++
 tb/tb_led_pattern_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared constants for the multi-channel LED pattern generator.
package led_pattern_pkg;

  localparam int unsigned PERIOD_W = 16;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  // Channel 0 wakes up as the legacy 1 s heartbeat.
  localparam logic [1:0] RST_MODE_CH0 = MODE_BLINK;

  function automatic logic [PERIOD_W-1:0] rst_period_ch0(input int unsigned tick_hz);
    return PERIOD_W'(tick_hz);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds config, tick counter, blink phase and breathe ramp.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int unsigned         PWM_BITS   = 8,
  parameter logic [1:0]          RST_MODE   = MODE_OFF,
  parameter logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(1),
  parameter logic [PWM_BITS-1:0] RST_DUTY   = '0
) (
  input  logic                clk,
  input  logic                a_reset_n,
  input  logic                tick,
  input  logic                wr,
  input  logic [1:0]          wr_mode,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [PWM_BITS-1:0] wr_duty,
  output logic [PWM_BITS-1:0] level_c
);

  logic [1:0]          mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PERIOD_W-1:0] tcnt_q;
  logic                phase_q;
  logic [PWM_BITS-1:0] blev_q;
  logic                dir_down_q;

  logic                expire_c;
  logic [PWM_BITS-1:0] blev_nx;
  logic                dir_nx;

  // Expiry fires on the tick that completes a full period of ticks.
  always_comb begin
    expire_c = tick && (tcnt_q == (period_q - PERIOD_W'(1)));
  end

  // Next breathe step: triangle ramp between 0 and the peak duty.
  always_comb begin
    blev_nx = blev_q;
    dir_nx  = dir_down_q;
    if (duty_q == '0) begin
      blev_nx = '0;
    end else if (!dir_down_q) begin
      blev_nx = blev_q + PWM_BITS'(1);
      if (blev_nx == duty_q) dir_nx = 1'b1;
    end else begin
      blev_nx = blev_q - PWM_BITS'(1);
      if (blev_nx == '0) dir_nx = 1'b0;
    end
  end

  // Channel state; a config write takes priority over a same-cycle expiry.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      mode_q     <= RST_MODE;
      period_q   <= RST_PERIOD;
      duty_q     <= RST_DUTY;
      tcnt_q     <= '0;
      phase_q    <= 1'b0;
      blev_q     <= '0;
      dir_down_q <= 1'b0;
    end else if (wr) begin
      mode_q     <= wr_mode;
      period_q   <= (wr_period == '0) ? PERIOD_W'(1) : wr_period;
      duty_q     <= wr_duty;
      tcnt_q     <= '0;
      phase_q    <= 1'b1;
      blev_q     <= '0;
      dir_down_q <= 1'b0;
    end else if (tick) begin
      tcnt_q <= expire_c ? '0 : tcnt_q + PERIOD_W'(1);
      if (expire_c && (mode_q == MODE_BLINK)) phase_q <= ~phase_q;
      if (expire_c && (mode_q == MODE_BREATHE)) begin
        blev_q     <= blev_nx;
        dir_down_q <= dir_nx;
      end
    end
  end

  // Brightness level presented to the shared PWM comparator.
  always_comb begin
    level_c = '0;
    case (mode_q)
      MODE_ON:      level_c = duty_q;
      MODE_BLINK:   level_c = phase_q ? duty_q : '0;
      MODE_BREATHE: level_c = blev_q;
      default:      level_c = '0;
    endcase
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared tick prescaler and PWM, per-channel patterns.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned PWM_BITS = 8,
  localparam int unsigned SEL_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                a_reset_n,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                tick_out
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned LIMIT   = DIV - 1;
  localparam int unsigned PRE_W   = $clog2(DIV);
  localparam int unsigned PWM_MAX = (2 ** PWM_BITS) - 2;

  logic [PRE_W-1:0]    pre_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic                tick_c;
  logic [PWM_BITS-1:0] level_c [NUM_LEDS];

  always_comb begin
    tick_c = (pre_q == PRE_W'(LIMIT));
  end

  // Millisecond-style tick prescaler and free-running PWM counter.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      pre_q <= '0;
      pwm_q <= '0;
    end else begin
      pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
      pwm_q <= (pwm_q == PWM_BITS'(PWM_MAX)) ? '0 : pwm_q + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    logic wr_c;
    // Write decode; selects beyond NUM_LEDS match no channel.
    always_comb begin
      wr_c = cfg_we && (cfg_sel == SEL_W'(i));
    end

    led_channel #(
      .PWM_BITS   (PWM_BITS),
      .RST_MODE   ((i == 0) ? RST_MODE_CH0 : MODE_OFF),
      .RST_PERIOD ((i == 0) ? rst_period_ch0(TICK_HZ) : PERIOD_W'(1)),
      .RST_DUTY   ((i == 0) ? {PWM_BITS{1'b1}} : {PWM_BITS{1'b0}})
    ) u_ch (
      .clk       (clk),
      .a_reset_n (a_reset_n),
      .tick      (tick_c),
      .wr        (wr_c),
      .wr_mode   (cfg_mode),
      .wr_period (cfg_period),
      .wr_duty   (cfg_duty),
      .level_c   (level_c[i])
    );
  end

  // Registered PWM comparator and tick pulse.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      led_out  <= '0;
      tick_out <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_out[i] <= (pwm_q < level_c[i]);
      end
      tick_out <= tick_c;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen against a tick-count reference model.
module tb_led_pattern_gen;

  localparam int LIMIT = 9;
  localparam int PWM_TOP = 6;
  localparam int NCH = 7;  // 0..3 main DUT, 4..6 three-channel DUT

  logic        clk = 1'b0;
  logic        a_reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic        cfg_we3 = 1'b0;
  logic [1:0]  cfg_sel3 = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic [2:0]  cfg_duty = '0;
  logic [3:0]  led_out;
  logic        tick_out;
  logic [2:0]  led3;
  logic        tick3;

  int errors = 0;
  int checks = 0;

  led_pattern_gen #(.NUM_LEDS(4), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(3)) dut (
    .clk(clk), .a_reset_n(a_reset_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .led_out(led_out), .tick_out(tick_out));

  led_pattern_gen #(.NUM_LEDS(3), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(3)) dut3 (
    .clk(clk), .a_reset_n(a_reset_n), .cfg_we(cfg_we3), .cfg_sel(cfg_sel3),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .led_out(led3), .tick_out(tick3));

  always #5 clk = ~clk;

  // Reference model: per channel, the config and the number of ticks since the last write.
  int m_mode [NCH];
  int m_per  [NCH];
  int m_duty [NCH];
  int m_ph0  [NCH];
  int m_n    [NCH];
  int p_cnt, pwm_cnt;
  logic [3:0] exp_led;
  logic [2:0] exp_led3;
  logic       exp_tick;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = (i == 0 || i == 4) ? 2 : 0;
      m_per[i]  = (i == 0 || i == 4) ? 100 : 1;
      m_duty[i] = (i == 0 || i == 4) ? 7 : 0;
      m_ph0[i]  = 0;
      m_n[i]    = 0;
    end
    p_cnt = 0;
    pwm_cnt = 0;
  endtask

  function automatic int lvl(int i);
    int k, pos, d;
    k = m_n[i] / m_per[i];
    d = m_duty[i];
    case (m_mode[i])
      1: return d;
      2: return ((m_ph0[i] ^ (k % 2)) != 0) ? d : 0;
      3: begin
        if (d == 0) return 0;
        pos = k % (2 * d);
        return (pos <= d) ? pos : 2 * d - pos;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_write(int i);
    m_mode[i] = int'(cfg_mode);
    m_per[i]  = (cfg_period == 16'd0) ? 1 : int'(cfg_period);
    m_duty[i] = int'(cfg_duty);
    m_ph0[i]  = 1;
    m_n[i]    = 0;
  endtask

  task automatic model_edge();
    logic tk;
    tk = (p_cnt == LIMIT);
    exp_tick = tk;
    for (int i = 0; i < 4; i++) exp_led[i] = (pwm_cnt < lvl(i));
    for (int i = 0; i < 3; i++) exp_led3[i] = (pwm_cnt < lvl(4 + i));
    for (int i = 0; i < NCH; i++) begin
      logic w;
      w = (i < 4) ? (cfg_we && int'(cfg_sel) == i)
                  : (cfg_we3 && int'(cfg_sel3) == i - 4);
      if (w) model_write(i);
      else if (tk) m_n[i]++;
    end
    p_cnt   = tk ? 0 : p_cnt + 1;
    pwm_cnt = (pwm_cnt == PWM_TOP) ? 0 : pwm_cnt + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("led_out", 32'(led_out), 32'(exp_led));
    check("tick_out", 32'(tick_out), 32'(exp_tick));
    check("led3", 32'(led3), 32'(exp_led3));
    check("tick3", 32'(tick3), 32'(exp_tick));
    cfg_we  = 1'b0;
    cfg_we3 = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] mode,
                    input logic [15:0] per, input logic [2:0] duty);
    cfg_we = 1'b1; cfg_sel = sel; cfg_mode = mode; cfg_period = per; cfg_duty = duty;
    step();
  endtask

  task automatic count_lit(input int ch, input int n, output int lit);
    lit = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (led_out[ch]) lit++;
    end
  endtask

  initial begin
    int lit;
    int guard;
    model_reset();
    // Reset defaults
    #12;
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_tick", 32'(tick_out), 32'd0);
    check("rst_led3", 32'(led3), 32'd0);
    @(negedge clk);
    a_reset_n = 1'b1;
    run(2100);

    // ON duty 3, then 7, then 0
    wr(2'd1, 2'd1, 16'd5, 3'd3);
    run(3);
    count_lit(1, 7, lit);
    check("on_duty3", 32'(lit), 32'd3);
    wr(2'd1, 2'd1, 16'd5, 3'd7);
    run(3);
    count_lit(1, 14, lit);
    check("on_duty7", 32'(lit), 32'd14);
    wr(2'd1, 2'd1, 16'd5, 3'd0);
    run(3);
    count_lit(1, 14, lit);
    check("on_duty0", 32'(lit), 32'd0);

    // BLINK period 2, then period 0
    wr(2'd2, 2'd2, 16'd2, 3'd7);
    run(30);
    count_lit(2, 40, lit);
    check("blink_p2", 32'(lit), 32'd20);
    run(50);
    wr(2'd2, 2'd2, 16'd0, 3'd7);
    run(15);
    count_lit(2, 20, lit);
    check("blink_p0", 32'(lit), 32'd10);
    run(40);

    // BREATHE period 1 duty 4
    wr(2'd3, 2'd3, 16'd1, 3'd4);
    run(200);

    // Write on the cycle channel 2 expires (period 1 expires every tick)
    guard = 0;
    while (p_cnt != LIMIT && guard < 20) begin
      step();
      guard++;
    end
    check("collide_wait", 32'(p_cnt == LIMIT), 32'd1);
    wr(2'd2, 2'd2, 16'd1, 3'd7);
    run(8);
    check("collide_lit", 32'(led_out[2]), 32'd1);

    // Out-of-range select on the three-channel instance
    cfg_we3 = 1'b1; cfg_sel3 = 2'd3; cfg_mode = 2'd1; cfg_period = 16'd1; cfg_duty = 3'd7;
    step();
    run(20);
    check("badsel", 32'(led3[2:1]), 32'd0);

    // Randomized writes on both instances
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) begin
        cfg_we = 1'b1;
        cfg_sel = 2'($urandom_range(3));
      end
      if ($urandom_range(7) == 0) begin
        cfg_we3 = 1'b1;
        cfg_sel3 = 2'($urandom_range(3));
      end
      cfg_mode = 2'($urandom_range(3));
      cfg_period = 16'($urandom_range(3));
      cfg_duty = 3'($urandom_range(7));
      step();
    end

    // Mid-run reset between edges
    wr(2'd1, 2'd1, 16'd1, 3'd7);
    run(5);
    check("pre_rst_on", 32'(led_out[1]), 32'd1);
    #2;
    a_reset_n = 1'b0;
    #1;
    check("async_led", 32'(led_out), 32'd0);
    check("async_tick", 32'(tick_out), 32'd0);
    check("async_led3", 32'(led3), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    a_reset_n = 1'b1;
    run(1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
